// File: rtl/mips_pkg.sv
// Shared MIPS definitions: word width, divider state encoding and the
// divide-by-zero quotient constant.
package mips_pkg;

   localparam int MIPS_WORD = 32;

   localparam logic [MIPS_WORD-1:0] DIV_ZERO_QUO = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage : mips_pkg

// File: rtl/mips_div_step.sv
// One restoring shift-subtract iteration: shifts {rem, quo} left by one and
// keeps the trial difference when it does not go negative.
module mips_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quo_next
);

   logic [W:0]   shifted;
   logic [W-1:0] trial;
   logic         fits;

   assign shifted = {rem, quo[W-1]};
   assign fits    = (shifted >= {1'b0, divisor});
   // When the divisor fits, the difference is below 2^W, so W bits suffice.
   assign trial   = shifted[W-1:0] - divisor;

   assign rem_next = fits ? trial : shifted[W-1:0];
   assign quo_next = {quo[W-2:0], fits};

endmodule : mips_div_step

// File: rtl/mips_div_32bit.sv
// Iterative restoring divider producing MIPS LO/HI through start/busy/done.
// Define MIPS_DIV_SIGNED_EN to honour is_signed (div); otherwise all divu.
module mips_div_32bit
   import mips_pkg::*;
#(
   parameter int WIDTH = MIPS_WORD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
   logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic             busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;
   logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;

   logic [WIDTH-1:0] a_mag, b_mag, step_rem, step_quo, quo_fix, rem_fix;
   logic             a_neg_in, quo_neg_in;

`ifdef MIPS_DIV_SIGNED_EN
   logic b_neg_in;
   assign a_neg_in   = is_signed & a[WIDTH-1];
   assign b_neg_in   = is_signed & b[WIDTH-1];
   assign a_mag      = a_neg_in ? -a : a;
   assign b_mag      = b_neg_in ? -b : b;
   assign quo_neg_in = a_neg_in ^ b_neg_in;
   assign quo_fix    = neg_quo_q ? -step_quo : step_quo;
   assign rem_fix    = neg_rem_q ? -step_rem : step_rem;
`else
   logic unused_sign;
   assign unused_sign = ^{is_signed, neg_quo_q, neg_rem_q};
   assign a_neg_in    = 1'b0;
   assign quo_neg_in  = 1'b0;
   assign a_mag       = a;
   assign b_mag       = b;
   assign quo_fix     = step_quo;
   assign rem_fix     = step_rem;
`endif

   mips_div_step #(.W(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvsr_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_comb begin
      // NOTE: every _d defaults to its _q (done to 0) so no path infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvsr_d      = dvsr_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      div_zero_d  = div_zero_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               if (b == '0) begin
                  state_d     = ST_DONE;
                  done_d      = 1'b1;
                  div_zero_d  = 1'b1;
                  quotient_d  = WIDTH'(DIV_ZERO_QUO);
                  remainder_d = a;
               end else begin
                  state_d    = ST_CALC;
                  div_zero_d = 1'b0;
                  cnt_d      = '0;
                  rem_d      = '0;
                  quo_d      = a_mag;
                  dvsr_d     = b_mag;
                  neg_quo_d  = quo_neg_in;
                  neg_rem_d  = a_neg_in;
               end
            end
         end
         ST_CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            // Results land on the same edge as the final iteration.
            if (cnt_q == LAST) begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               quotient_d  = quo_fix;
               remainder_d = rem_fix;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_q      <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvsr_q      <= dvsr_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         div_zero_q  <= div_zero_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule : mips_div_32bit

// File: tb/tb_mips_div_32bit.sv
// Directed self-checking bench for mips_div_32bit; signed expectations follow
// whether MIPS_DIV_SIGNED_EN is defined for the build.
module tb_mips_div_32bit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;

   int nvec = 0;
   int nerr = 0;

   mips_div_32bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives start for one cycle; returns at the negedge of cycle 1.
   task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sv);
      @(negedge clk);
      start = 1'b1; a = av; b = bv; is_signed = sv;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output logic busy_ok);
      cyc = 1;
      busy_ok = 1'b1;
      while (done !== 1'b1 && cyc < 60) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
      #12;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
      nvec++; if (quotient !== 32'h0) begin nerr++; $display("FAIL reset_quo got %h want 0", quotient); end
      nvec++; if (remainder !== 32'h0) begin nerr++; $display("FAIL reset_rem got %h want 0", remainder); end
      nvec++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL reset_dz got %b want 0", div_zero); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned;
      int cyc; logic bok;
      issue(32'd100, 32'd7, 1'b0);
      wait_done(cyc, bok);
      nvec++; if (cyc !== 33) begin nerr++; $display("FAIL u_done_cycle got %0d want 33", cyc); end
      nvec++; if (bok !== 1'b1) begin nerr++; $display("FAIL u_busy_span got %b want 1", bok); end
      nvec++; if (quotient !== 32'd14) begin nerr++; $display("FAIL u_quo got %h want 0000000e", quotient); end
      nvec++; if (remainder !== 32'd2) begin nerr++; $display("FAIL u_rem got %h want 00000002", remainder); end
      nvec++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL u_dz got %b want 0", div_zero); end
      @(negedge clk);
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL u_done_pulse got %b want 0", done); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL u_busy_c34 got %b want 0", busy); end
      nvec++; if (quotient !== 32'd14) begin nerr++; $display("FAIL u_quo_hold got %h want 0000000e", quotient); end
   endtask

   task automatic test_signed;
      int cyc; logic bok;
      logic [31:0] exp_q1, exp_r1, exp_q2, exp_r2;
`ifdef MIPS_DIV_SIGNED_EN
      exp_q1 = 32'hFFFF_FFFD; exp_r1 = 32'hFFFF_FFFF;
      exp_q2 = 32'h8000_0000; exp_r2 = 32'h0000_0000;
`else
      exp_q1 = 32'h7FFF_FFFC; exp_r1 = 32'h0000_0001;
      exp_q2 = 32'h0000_0000; exp_r2 = 32'h8000_0000;
`endif
      issue(32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done(cyc, bok);
      nvec++; if (cyc !== 33) begin nerr++; $display("FAIL s_done_cycle got %0d want 33", cyc); end
      nvec++; if (quotient !== exp_q1) begin nerr++; $display("FAIL s_quo got %h want %h", quotient, exp_q1); end
      nvec++; if (remainder !== exp_r1) begin nerr++; $display("FAIL s_rem got %h want %h", remainder, exp_r1); end
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done(cyc, bok);
      nvec++; if (cyc !== 33) begin nerr++; $display("FAIL ovf_done_cycle got %0d want 33", cyc); end
      nvec++; if (quotient !== exp_q2) begin nerr++; $display("FAIL ovf_quo got %h want %h", quotient, exp_q2); end
      nvec++; if (remainder !== exp_r2) begin nerr++; $display("FAIL ovf_rem got %h want %h", remainder, exp_r2); end
      nvec++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL ovf_dz got %b want 0", div_zero); end
   endtask

   task automatic test_div_zero;
      issue(32'h0000_1234, 32'd0, 1'b0);
      nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL dz_done_c1 got %b want 1", done); end
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL dz_busy_c1 got %b want 1", busy); end
      nvec++; if (quotient !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL dz_quo got %h want ffffffff", quotient); end
      nvec++; if (remainder !== 32'h0000_1234) begin nerr++; $display("FAIL dz_rem got %h want 00001234", remainder); end
      nvec++; if (div_zero !== 1'b1) begin nerr++; $display("FAIL dz_flag got %b want 1", div_zero); end
      @(negedge clk);
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL dz_busy_c2 got %b want 0", busy); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL dz_done_c2 got %b want 0", done); end
      nvec++; if (div_zero !== 1'b1) begin nerr++; $display("FAIL dz_flag_hold got %b want 1", div_zero); end
   endtask

   task automatic test_back_to_back;
      int cyc; logic bok;
      issue(32'hFFFF_FFFF, 32'd16, 1'b0);
      nvec++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL b2b_dz_clear got %b want 0", div_zero); end
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy_c1 got %b want 1", busy); end
      wait_done(cyc, bok);
      nvec++; if (cyc !== 33) begin nerr++; $display("FAIL b2b_done_cycle got %0d want 33", cyc); end
      nvec++; if (quotient !== 32'h0FFF_FFFF) begin nerr++; $display("FAIL b2b_quo got %h want 0fffffff", quotient); end
      nvec++; if (remainder !== 32'h0000_000F) begin nerr++; $display("FAIL b2b_rem got %h want 0000000f", remainder); end
      @(negedge clk);
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL b2b_busy_c34 got %b want 0", busy); end
      start = 1'b1; a = 32'd1000; b = 32'd10; is_signed = 1'b0;
      @(negedge clk);
      start = 1'b0;
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_accept_c35 got %b want 1", busy); end
      wait_done(cyc, bok);
      nvec++; if (cyc !== 33) begin nerr++; $display("FAIL b2b2_done_cycle got %0d want 33", cyc); end
      nvec++; if (quotient !== 32'd100) begin nerr++; $display("FAIL b2b2_quo got %h want 00000064", quotient); end
      nvec++; if (remainder !== 32'd0) begin nerr++; $display("FAIL b2b2_rem got %h want 00000000", remainder); end
   endtask

   task automatic test_ignored_start;
      int cyc;
      issue(32'd100, 32'd7, 1'b0);
      cyc = 1;
      while (done !== 1'b1 && cyc < 60) begin
         if (cyc == 5) begin start = 1'b1; a = 32'd1; b = 32'd1; end
         if (cyc == 6) start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      nvec++; if (cyc !== 33) begin nerr++; $display("FAIL ign_done_cycle got %0d want 33", cyc); end
      nvec++; if (quotient !== 32'd14) begin nerr++; $display("FAIL ign_quo got %h want 0000000e", quotient); end
      nvec++; if (remainder !== 32'd2) begin nerr++; $display("FAIL ign_rem got %h want 00000002", remainder); end
      start = 1'b1; a = 32'd50; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL ign_done_start_c34 got %b want 0", busy); end
      @(negedge clk);
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL ign_done_start_c35 got %b want 0", busy); end
      nvec++; if (quotient !== 32'd14) begin nerr++; $display("FAIL ign_quo_hold got %h want 0000000e", quotient); end
   endtask

   task automatic test_reset_mid;
      int cyc; logic bok;
      issue(32'd100, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy got %b want 0", busy); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rmid_done got %b want 0", done); end
      nvec++; if (quotient !== 32'h0) begin nerr++; $display("FAIL rmid_quo got %h want 0", quotient); end
      nvec++; if (remainder !== 32'h0) begin nerr++; $display("FAIL rmid_rem got %h want 0", remainder); end
      nvec++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL rmid_dz got %b want 0", div_zero); end
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'd9, 32'd3, 1'b0);
      wait_done(cyc, bok);
      nvec++; if (cyc !== 33) begin nerr++; $display("FAIL rpost_done_cycle got %0d want 33", cyc); end
      nvec++; if (quotient !== 32'd3) begin nerr++; $display("FAIL rpost_quo got %h want 00000003", quotient); end
      nvec++; if (remainder !== 32'd0) begin nerr++; $display("FAIL rpost_rem got %h want 00000000", remainder); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_back_to_back();
      test_ignored_start();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule : tb_mips_div_32bit

// File: doc/mips_div_32bit.md
# mips_div_32bit

Iterative 32-bit integer divider for the single-cycle MIPS datapath.
- Complements the combinational ALU with the inverse of multiplication: restoring shift-subtract division, one quotient bit per clock.
- Produces MIPS-style LO (quotient) and HI (remainder) results through a start/busy/done handshake.
- Sits beside the ALU. The control path stalls the PC while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width in bits; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `is_signed`  in  1  1 = `div`, 0 = `divu`; sampled with `start`.
- `a`  in  WIDTH  dividend; sampled with `start`.
- `b`  in  WIDTH  divisor; sampled with `start`.
- `busy`  out  1  high from the cycle after accept until `done`.
- `done`  out  1  one-cycle pulse when results are valid.
- `quotient`  out  WIDTH  LO result, registered.
- `remainder`  out  WIDTH  HI result, registered.
- `div_zero`  out  1  divisor was zero; valid with `done`, held until next accept.

## Operation
States:
- **IDLE**
  - `start`=1 and `b`≠0 → latch operands → CALC, iteration counter = 0.
  - `start`=1 and `b`=0 → DONE.
- **CALC**
  - Each cycle: shift {rem, quo} left 1; trial = rem − |b| (WIDTH+1 bits).
  - Trial non-negative → rem = trial, quo[0] = 1; otherwise restore, quo[0] = 0.
  - Counter reaches WIDTH−1 → DONE.
- **DONE**
  - Apply sign fixup, drive results, pulse `done` → IDLE.

Arithmetic rules:
- Unsigned: straight restoring division on `a`, `b`.
- Signed:
  - Operate on magnitudes.
  - Quotient negated when sign(a)≠sign(b).
  - Remainder takes sign of `a`.
  - -2^31 / -1 yields quotient 0x80000000, remainder 0. No trap.
- Divide by zero: quotient = all ones, remainder = `a` unmodified, `div_zero`=1.

Boundary conditions:
- `start` while not IDLE is ignored; operands are not re-sampled.
- Results hold stable from `done` until the next accepted `start`.
- `start` in the same cycle as `done` is ignored; accept occurs only from IDLE.
- Reset mid-operation aborts the division. All outputs go to reset values immediately.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0, state IDLE.
- Accept edge = cycle 0.
- Normal divide:
  - `busy` is high cycles 1..WIDTH+1.
  - `done` is high in cycle WIDTH+1: 33 for the default.
- Divide by zero: `busy` and `done` high in cycle 1 only.
- `busy` deasserts in the cycle after `done`. Back-to-back accept is possible at cycle WIDTH+2.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
`MIPS_DIV_SIGNED_EN`:
- **Defined:** `is_signed` is honoured; magnitude conversion and sign-fixup logic are compiled in.
- **Undefined:** `is_signed` is ignored and every operation is unsigned; no negation logic is synthesized.
- Cycle timing is identical in both builds.

## Structure
- Shared package `mips_pkg`:
  - divider state enum (IDLE/CALC/DONE).
  - `MIPS_WORD` = 32.
  - Divide-by-zero quotient constant (all ones).
- One sub-module, `mips_div_step`: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in the CALC datapath.

## Test plan
- Unsigned: a=100, b=7, `divu` → at cycle 33: quotient 14, remainder 2, `done` pulse 1 cycle, `busy` low cycle 34.
- Signed (macro defined): a=-7 (0xFFFFFFF9), b=2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF → quotient 0x80000000, remainder 0, `div_zero`=0.
- Divide by zero: a=0x1234, b=0 → `done` at cycle 1, quotient 0xFFFFFFFF, remainder 0x1234, `div_zero`=1.
- `start` pulsed at cycle 5 with a=1, b=1 during a 100/7 run → ignored; results still 14/2 at cycle 33.
- `rst_n` low at cycle 10 of a run → all outputs 0 asynchronously; a fresh 9/3 afterwards → quotient 3, remainder 0.
